power_meter: RTL and testbench
==============================

# power_meter

Sample-stream consumer for real-valued voltage/current pairs, such as those produced by the sine source and resistor models. Over a fixed window of accepted samples it accumulates energy and squared terms. At the end of each window it publishes average power, RMS voltage, RMS current and peak instantaneous power, with a one-cycle result strobe. It is the measurement end of the stimulus chain: it checks dissipation numerically in the bench instead of only dumping waveforms.

## Interface
- SAMPLES_PER_WINDOW, 100, number of accepted samples per measurement window; integer, ≥1
- clk  input  1  sampling clock, posedge active
- reset  input  1  asynchronous, active-high; clears all state and outputs
- sample_valid  input  1  voltage_in/current_in accepted on posedge clk when high
- voltage_in  input  real  instantaneous voltage, volts
- current_in  input  real  instantaneous current, amperes
- result_valid  output  1  high for exactly one cycle after a window closes
- avg_power  output  real  mean of v·i over the window, watts
- v_rms  output  real  sqrt(mean v²), volts
- i_rms  output  real  sqrt(mean i²), amperes
- peak_power  output  real  max |v·i| over the window, watts
- window_count  output  32  number of completed windows since reset

## Operation
- States: SYNC (only when the Configuration macro is defined), ACCUM.
- Internal state: sample_idx (integer 0..N-1), sum_p, sum_v2, sum_i2, max_p (real).
- Reset values:
  - result_valid=0; avg_power=v_rms=i_rms=peak_power=0.0; window_count=0.
  - All sums and max_p = 0.0; sample_idx=0.
  - State = SYNC if the macro is defined, else ACCUM.
- ACCUM, edge with sample_valid=1 and sample_idx<N-1:
  - Add v·i, v², i² to the sums.
  - max_p = max(max_p, |v·i|).
  - sample_idx += 1.
- ACCUM, edge with sample_valid=1 and sample_idx==N-1 (window close):
  - Compute the final totals including the current sample.
  - avg_power=sum_p/N; v_rms=sqrt(sum_v2/N); i_rms=sqrt(sum_i2/N); peak_power=final max.
  - result_valid=1; window_count += 1, wrapping 2³²-1→0.
  - Clear sums, max_p and sample_idx in the same edge.
  - The next accepted sample starts a new window; there are no dead cycles.
- sample_valid=0: all accumulators hold. Gaps of any length are allowed and do not affect results.
- Result outputs hold their last values until the next window close; only result_valid pulses.
- Division uses real N (SAMPLES_PER_WINDOW converted to real). No integer truncation anywhere in the arithmetic path.
- Negative power samples are legal: they subtract from sum_p and use their magnitude for peak.

## Timing
- Latency: results and result_valid are visible immediately after the posedge that accepts sample N of the window.
- result_valid deasserts at the following posedge unless that edge also closes a window. This is possible only when N=1, in which case result_valid stays high while samples arrive every cycle.
- Reset mid-window: the partial window is discarded, outputs return to reset values, and the count restarts from sample 0 (or from SYNC).
- Reset asserted on the same edge as a window close: reset wins and no result is published.
- Throughput: one sample per clock maximum.

## Configuration
- POWER_METER_ZERO_CROSS_SYNC_EN defined:
  - After reset the block sits in SYNC and holds a registered prev_v plus a prev_ok flag; prev_ok is cleared by reset.
  - SYNC→ACCUM on the first accepted sample where prev_ok=1, prev_v<0.0 and voltage_in≥0.0. That sample is sample 0 of the first window.
  - Samples accepted in SYNC are not accumulated.
  - Sync happens once per reset; later windows run back-to-back without re-sync.
- Not defined: SYNC state and prev_v are absent, and the first accepted sample after reset is sample 0.

## Test plan
- DC: v=10.0, i=0.1 for 100 valid cycles, N=100 → one result_valid pulse with avg_power=1.0, v_rms=10.0, i_rms=0.1, peak_power=1.0, window_count=1.
- Sine source at 170.0 V peak into 100 Ω, 100 samples/cycle, N=100, 5 windows → each window gives avg_power=144.5, v_rms≈120.208, i_rms≈1.20208, peak_power=289.0 (relative tolerance 1e-6); window_count reaches 5.
- Same DC stimulus with sample_valid low on every other cycle → results identical to the DC case, and result_valid occurs after 199 clocks.
- Reset asserted after sample 40, then 100 DC samples of v=5.0, i=0.05 → outputs read 0.0 during reset; the first result is avg_power=0.25, window_count=1, with no contamination from the earlier samples.
- With POWER_METER_ZERO_CROSS_SYNC_EN, sine starting at sample index 50 (negative half-cycle) → no accumulation until the wrap to index 0; the first result arrives 150 samples after start and equals the sine case values.
- Alternating v=+10/i=+1 and v=-10/i=+1, N=2 → avg_power=0.0, v_rms=10.0, i_rms=1.0, peak_power=10.0, with result_valid high every second cycle.

Source files
------------

// File: rtl/power_meter.sv
// power_meter: windowed average power, RMS voltage/current and peak power over real-valued v/i samples.
// Optional macro POWER_METER_ZERO_CROSS_SYNC_EN holds off the first window until a rising zero crossing of voltage_in.
module power_meter #(
   parameter int SAMPLES_PER_WINDOW = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sample_valid,
   input  real         voltage_in,
   input  real         current_in,
   output logic        result_valid,
   output real         avg_power,
   output real         v_rms,
   output real         i_rms,
   output real         peak_power,
   output logic [31:0] window_count
);
   localparam logic [31:0] LAST_IDX = 32'(SAMPLES_PER_WINDOW - 1);
   localparam real         N_REAL   = real'(SAMPLES_PER_WINDOW);

   typedef enum logic {ACCUM, SYNC} state_t;

`ifdef POWER_METER_ZERO_CROSS_SYNC_EN
   localparam state_t RESET_STATE = SYNC;
`else
   localparam state_t RESET_STATE = ACCUM;
`endif

   state_t      state;
   state_t      state_next;
   logic [31:0] sample_idx;
   real         sum_p;
   real         sum_v2;
   real         sum_i2;
   real         max_p;

   logic        sync_hit;
   logic        accept;
   logic        close;
   real         p;
   real         abs_p;
   real         sum_p_next;
   real         sum_v2_next;
   real         sum_i2_next;
   real         max_p_next;

`ifdef POWER_METER_ZERO_CROSS_SYNC_EN
   real  prev_v;
   logic prev_ok;

   // The sample that completes the negative-to-non-negative crossing is itself sample 0.
   assign sync_hit = sample_valid && (state == SYNC) && prev_ok &&
                     (prev_v < 0.0) && (voltage_in >= 0.0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_v  <= 0.0;
         prev_ok <= 1'b0;
      end else if (sample_valid && state == SYNC) begin
         prev_v  <= voltage_in;
         prev_ok <= 1'b1;
      end
   end
`else
   assign sync_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RESET_STATE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (state == SYNC && sync_hit) state_next = ACCUM;
   end

   always_comb begin
      accept      = sample_valid && ((state == ACCUM) || sync_hit);
      close       = accept && (sample_idx == LAST_IDX);
      p           = voltage_in * current_in;
      abs_p       = (p < 0.0) ? -p : p;
      sum_p_next  = sum_p + p;
      sum_v2_next = sum_v2 + voltage_in * voltage_in;
      sum_i2_next = sum_i2 + current_in * current_in;
      max_p_next  = (abs_p > max_p) ? abs_p : max_p;
   end

   // Window close publishes totals that include the closing sample and clears the accumulators in the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_idx   <= '0;
         sum_p        <= 0.0;
         sum_v2       <= 0.0;
         sum_i2       <= 0.0;
         max_p        <= 0.0;
         result_valid <= 1'b0;
         avg_power    <= 0.0;
         v_rms        <= 0.0;
         i_rms        <= 0.0;
         peak_power   <= 0.0;
         window_count <= '0;
      end else begin
         result_valid <= close;
         if (close) begin
            avg_power    <= sum_p_next / N_REAL;
            v_rms        <= $sqrt(sum_v2_next / N_REAL);
            i_rms        <= $sqrt(sum_i2_next / N_REAL);
            peak_power   <= max_p_next;
            window_count <= window_count + 32'd1;
            sample_idx   <= '0;
            sum_p        <= 0.0;
            sum_v2       <= 0.0;
            sum_i2       <= 0.0;
            max_p        <= 0.0;
         end else if (accept) begin
            sample_idx <= sample_idx + 32'd1;
            sum_p      <= sum_p_next;
            sum_v2     <= sum_v2_next;
            sum_i2     <= sum_i2_next;
            max_p      <= max_p_next;
         end
      end
   end
endmodule

// File: tb/tb_power_meter.sv
// tb_power_meter: directed vectors for power_meter with N=100, N=2 and N=1 instances on shared stimulus.
// Build with POWER_METER_ZERO_CROSS_SYNC_EN defined to exercise the zero-crossing sync start instead.
module tb_power_meter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic sample_valid;
   real  voltage_in;
   real  current_in;

   logic        rv_a, rv_b, rv_c;
   real         avg_a, vr_a, ir_a, pk_a;
   real         avg_b, vr_b, ir_b, pk_b;
   real         avg_c, vr_c, ir_c, pk_c;
   logic [31:0] wc_a, wc_b, wc_c;

   int checks = 0;
   int errors = 0;

   power_meter #(.SAMPLES_PER_WINDOW(100)) dut_a (
      .clk(clk), .reset(reset), .sample_valid(sample_valid),
      .voltage_in(voltage_in), .current_in(current_in),
      .result_valid(rv_a), .avg_power(avg_a), .v_rms(vr_a), .i_rms(ir_a),
      .peak_power(pk_a), .window_count(wc_a));

   power_meter #(.SAMPLES_PER_WINDOW(2)) dut_b (
      .clk(clk), .reset(reset), .sample_valid(sample_valid),
      .voltage_in(voltage_in), .current_in(current_in),
      .result_valid(rv_b), .avg_power(avg_b), .v_rms(vr_b), .i_rms(ir_b),
      .peak_power(pk_b), .window_count(wc_b));

   power_meter #(.SAMPLES_PER_WINDOW(1)) dut_c (
      .clk(clk), .reset(reset), .sample_valid(sample_valid),
      .voltage_in(voltage_in), .current_in(current_in),
      .result_valid(rv_c), .avg_power(avg_c), .v_rms(vr_c), .i_rms(ir_c),
      .peak_power(pk_c), .window_count(wc_c));

   typedef struct {
      real v;
      real i;
      bit  gaps;
      real exp_avg;
      real exp_vrms;
      real exp_irms;
      real exp_peak;
      int  exp_clocks;
   } vec_t;

   vec_t vecs[4];

   // Drive one cycle of inputs and return #1 after the edge that consumes them.
   task automatic applyStimulus(input logic valid, input real v, input real i);
      sample_valid = valid;
      voltage_in   = v;
      current_in   = i;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic checkOutputReal(input string name, input real act, input real exp);
      real diff;
      checks++;
      diff = (act > exp) ? act - exp : exp - act;
      if (diff > 1.0e-6 * ((exp < 0.0) ? -exp : exp) + 1.0e-9) begin
         errors++;
         $display("[TB] FAIL %s actual=%g required=%g", name, act, exp);
      end
   endtask

   task automatic doReset();
      reset        = 1'b1;
      sample_valid = 1'b0;
      voltage_in   = 0.0;
      current_in   = 0.0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic real sineV(input int k);
      return 170.0 * $sin(2.0 * 3.14159265358979323846 * real'(k % 100) / 100.0);
   endfunction

   initial begin
      int   early;
      int   clocks;
      int   accepted;
      bit   seen;
      real  v;

      vecs[0] = '{ 10.0,  0.1, 1'b0,  1.0,  10.0, 0.1,  1.0, 100};
      vecs[1] = '{ 10.0,  0.1, 1'b1,  1.0,  10.0, 0.1,  1.0, 199};
      vecs[2] = '{ -4.0,  0.5, 1'b0, -2.0,   4.0, 0.5,  2.0, 100};
      vecs[3] = '{  3.0, -2.0, 1'b1, -6.0,   3.0, 2.0,  6.0, 199};

      doReset();
      checkOutput("reset_result_valid", rv_a, 0);
      checkOutput("reset_window_count", wc_a, 0);
      checkOutputReal("reset_avg_power", avg_a, 0.0);
      checkOutputReal("reset_peak_power", pk_a, 0.0);

`ifdef POWER_METER_ZERO_CROSS_SYNC_EN
      // Start mid-cycle in the negative half; accumulation begins at the wrap to index 0.
      seen   = 1'b0;
      clocks = 0;
      for (int k = 50; k < 260 && !seen; k++) begin
         v = sineV(k);
         applyStimulus(1'b1, v, v / 100.0);
         clocks++;
         if (rv_a) seen = 1'b1;
      end
      checkOutput("sync_first_result_samples", clocks, 150);
      checkOutputReal("sync_avg_power", avg_a, 144.5);
      checkOutputReal("sync_v_rms", vr_a, 170.0 / $sqrt(2.0));
      checkOutputReal("sync_i_rms", ir_a, 1.7 / $sqrt(2.0));
      checkOutputReal("sync_peak_power", pk_a, 289.0);
      checkOutput("sync_window_count", wc_a, 1);
      for (int k = 0; k < 100; k++) begin
         v = sineV(k);
         applyStimulus(1'b1, v, v / 100.0);
      end
      checkOutput("sync_second_window_back_to_back", rv_a, 1);
      checkOutput("sync_window_count_2", wc_a, 2);
`else
      for (int t = 0; t < 4; t++) begin
         doReset();
         clocks   = 0;
         accepted = 0;
         early    = 0;
         seen     = 1'b0;
         while (!seen && clocks < 400) begin
            if (vecs[t].gaps && (clocks % 2 == 1))
               applyStimulus(1'b0, 0.0, 0.0);
            else
               applyStimulus(1'b1, vecs[t].v, vecs[t].i);
            clocks++;
            if (rv_a) seen = 1'b1;
         end
         checkOutput($sformatf("vec%0d_result_clock", t), clocks, vecs[t].exp_clocks);
         checkOutputReal($sformatf("vec%0d_avg_power", t), avg_a, vecs[t].exp_avg);
         checkOutputReal($sformatf("vec%0d_v_rms", t), vr_a, vecs[t].exp_vrms);
         checkOutputReal($sformatf("vec%0d_i_rms", t), ir_a, vecs[t].exp_irms);
         checkOutputReal($sformatf("vec%0d_peak_power", t), pk_a, vecs[t].exp_peak);
         checkOutput($sformatf("vec%0d_window_count", t), wc_a, 1);
         applyStimulus(1'b0, 99.0, 99.0);
         checkOutput($sformatf("vec%0d_pulse_one_cycle", t), rv_a, 0);
         checkOutputReal($sformatf("vec%0d_avg_held", t), avg_a, vecs[t].exp_avg);
      end

      // Five back-to-back sine windows, 170 V peak into 100 ohm.
      doReset();
      for (int w = 0; w < 5; w++) begin
         early = 0;
         for (int k = 0; k < 100; k++) begin
            v = sineV(k);
            applyStimulus(1'b1, v, v / 100.0);
            if (k < 99 && rv_a) early++;
         end
         checkOutput($sformatf("sine%0d_no_early_pulse", w), early, 0);
         checkOutput($sformatf("sine%0d_result_valid", w), rv_a, 1);
         checkOutputReal($sformatf("sine%0d_avg_power", w), avg_a, 144.5);
         checkOutputReal($sformatf("sine%0d_v_rms", w), vr_a, 170.0 / $sqrt(2.0));
         checkOutputReal($sformatf("sine%0d_i_rms", w), ir_a, 1.7 / $sqrt(2.0));
         checkOutputReal($sformatf("sine%0d_peak_power", w), pk_a, 289.0);
      end
      checkOutput("sine_window_count", wc_a, 5);

      // Reset after 40 samples of a partial window discards it.
      for (int k = 0; k < 40; k++) applyStimulus(1'b1, 10.0, 0.1);
      reset = 1'b1;
      #1;
      checkOutputReal("midreset_avg_power", avg_a, 0.0);
      checkOutputReal("midreset_v_rms", vr_a, 0.0);
      checkOutput("midreset_window_count", wc_a, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 100; k++) applyStimulus(1'b1, 5.0, 0.05);
      checkOutput("postreset_result_valid", rv_a, 1);
      checkOutputReal("postreset_avg_power", avg_a, 0.25);
      checkOutputReal("postreset_peak_power", pk_a, 0.25);
      checkOutput("postreset_window_count", wc_a, 1);

      // Reset on the same edge as a window close wins.
      doReset();
      for (int k = 0; k < 99; k++) applyStimulus(1'b1, 10.0, 0.1);
      reset = 1'b1;
      applyStimulus(1'b1, 10.0, 0.1);
      checkOutput("resetwins_result_valid", rv_a, 0);
      checkOutput("resetwins_window_count", wc_a, 0);
      reset = 1'b0;

      // Alternating +10/-10 V at 1 A: N=2 pulses every second cycle, N=1 stays high.
      doReset();
      early = 0;
      for (int k = 0; k < 8; k++) begin
         v = (k % 2 == 0) ? 10.0 : -10.0;
         applyStimulus(1'b1, v, 1.0);
         if (rv_b != logic'(k % 2 == 1)) early++;
         checkOutput($sformatf("n1_result_valid_%0d", k), rv_c, 1);
         checkOutputReal($sformatf("n1_avg_power_%0d", k), avg_c, v);
         checkOutput($sformatf("n1_window_count_%0d", k), wc_c, k + 1);
      end
      checkOutput("n2_pulse_pattern_errors", early, 0);
      checkOutputReal("n2_avg_power", avg_b, 0.0);
      checkOutputReal("n2_v_rms", vr_b, 10.0);
      checkOutputReal("n2_i_rms", ir_b, 1.0);
      checkOutputReal("n2_peak_power", pk_b, 10.0);
      checkOutput("n2_window_count", wc_b, 4);
      applyStimulus(1'b0, 0.0, 0.0);
      checkOutput("n1_drops_on_gap", rv_c, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
